instr_fetch_fsm: RTL and testbench
==================================

// Module: instr_fetch_fsm
// PURPOSE
//  IF stage sitting directly upstream of the hazard control unit. Holds the PC and applies the
//  hazard unit's En_PC/PCSrc selection to pick the next PC. Runs a req/gnt/rvalid handshake to
//  instruction memory and presents PC+instruction to the IF/ID register.
//  fetch_done_o drives HAZARD_i.I_FSM_STALL_FETCH; 1 = instruction ready, PC/IFID may advance.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  TRAP_VEC   32'h0000_0100  target for PCSrc=trap_illegal
//  NOP_INSTR  32'h0000_0013  value of instr_o while no valid instruction (addi x0,x0,0)
// PORTS
//  clk            in   1           single clock, rising edge
//  rst            in   1           synchronous reset, active-high
//  en_pc_i        in   1           HAZARD_o.En_PC
//  pcsrc_i        in   PCSrc_Enum  HAZARD_o.PCSrc
//  alu_target_i   in   32          branch target from ALU (branch_alu)
//  jump_target_i  in   32          PC-relative jump target (branch_pc_jump)
//  xepc_i         in   32          return address for MRET (xepc)
//  imem_req_o     out  1           request valid
//  imem_addr_o    out  32          request address; stable while req=1 and gnt=0
//  imem_gnt_i     in   1           request accepted this cycle
//  imem_rvalid_i  in   1           read data valid; at most one outstanding request
//  imem_rdata_i   in   32          read data
//  pc_o           out  32          PC of instr_o
//  instr_o        out  32          fetched instruction, NOP_INSTR when not valid
//  fetch_done_o   out  1           to HAZARD_i.I_FSM_STALL_FETCH
//  fetch_misalign_o out 1          only with IFETCH_MISALIGN_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, pc_q=RESET_PC, addr_q=RESET_PC, drop_q=0, imem_req_o=0,
//   instr_o=NOP_INSTR, fetch_done_o=0, pc_o=RESET_PC.
//  FSM (all outputs registered except imem_req_o, which is decoded from state):
//   IDLE  -> REQ unconditionally (one bubble cycle after reset).
//   REQ   imem_req_o=1, imem_addr_o=addr_q. gnt=1 -> WAIT. Else stay.
//   WAIT  rvalid=1 and drop_q=0 -> VALID; latch instr_o=rdata and pc_o=addr_q.
//         rvalid=1 and drop_q=1 -> REQ with addr_q=pc_q; drop_q cleared; data discarded.
//   VALID fetch_done_o=1. en_pc_i=1 -> pc_q=addr_q=npc and state=REQ. Same edge:
//         fetch_done_o->0 and instr_o->NOP_INSTR.
//  npc by pcsrc_i: next_pc -> pc_o+4; branch_alu -> alu_target_i;
//   branch_pc_jump -> jump_target_i; xepc -> xepc_i; trap_illegal -> TRAP_VEC.
//  All additions are 32-bit, modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
//  Redirect while in REQ or WAIT (en_pc_i=1 and pcsrc_i!=next_pc):
//   pc_q=npc. drop_q=1. addr_q is not changed in REQ, so the outstanding handshake completes.
//   Its response is dropped, then the new PC is fetched.
//   A second redirect before the drop overwrites pc_q; last one wins.
//  en_pc_i=1 with pcsrc_i=next_pc outside VALID: ignored.
//  rvalid in IDLE/REQ/VALID: ignored (protocol error, no state change).
//  Fetch latency: gnt and rvalid both in the cycle after req -> fetch_done_o 3 cycles after REQ entry.
//  rst mid-transaction: returns to the reset state and abandons the outstanding request.
//   The memory is on the same rst.
// CONFIGURATION
//  `IFETCH_MISALIGN_EN defined:
//   - A redirect target with npc[1:0]!=0 is not fetched.
//   - FSM -> VALID with instr_o=NOP_INSTR, pc_o=npc, and fetch_misalign_o=1 for that entry.
//   - The flag clears when VALID is left.
//  Not defined: port tied 0. npc[1:0] forced to 2'b00 before use.
// STRUCTURE
//  my_pkg: reuse PCSrc_Enum. Add fetch_state_e {IDLE,REQ,WAIT,VALID}, NOP_INSTR constant,
//   and an imem_req_t/imem_rsp_t struct pair.
//  One sub-module: pc_next_mux (combinational npc select + misalign check). FSM stays in top.
// TESTING
//  1 Reset, gnt/rvalid next cycle each, rdata=0x00500093:
//    fetch_done_o=1 on cycle 3 after REQ entry, pc_o=0, instr_o=0x00500093.
//  2 VALID, en_pc=1, pcsrc=next_pc: imem_addr_o=4 in next REQ.
//    gnt held low 5 cycles: addr stays 4, req stays 1.
//  3 In WAIT, en_pc=1, pcsrc=branch_alu, alu_target=0x40:
//    pending rdata dropped, next request addr=0x40, pc_o=0x40 when done.
//  4 pcsrc=trap_illegal -> fetch 0x100. pcsrc=xepc, xepc_i=0x88 -> fetch 0x88.
//  5 pc_o=0xFFFF_FFFC, next_pc -> addr 0. rst asserted in WAIT -> IDLE.
//    Next request at RESET_PC. Late rvalid ignored.
//  6 IFETCH_MISALIGN_EN: jump_target=0x42 -> no imem_req, fetch_misalign_o=1, pc_o=0x42.

Source files
------------

// File: rtl/instr_fetch_fsm_pkg.sv
// Shared types for the instruction fetch stage.
// IFETCH_MISALIGN_EN: when defined, misaligned redirect targets are flagged
// instead of being silently aligned.
package instr_fetch_fsm_pkg;

  typedef enum logic [2:0] {
    next_pc        = 3'd0,
    branch_alu     = 3'd1,
    branch_pc_jump = 3'd2,
    xepc           = 3'd3,
    trap_illegal   = 3'd4
  } PCSrc_Enum;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} fetch_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

`ifdef IFETCH_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } imem_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } imem_rsp_t;

endpackage

// File: rtl/instr_fetch_fsm_pc_next_mux.sv
// Next-PC select from the hazard unit's PCSrc, plus the misalignment check.
// IFETCH_MISALIGN_EN (via package): pass the target through and flag bits [1:0];
// otherwise force word alignment and never flag.
module instr_fetch_fsm_pc_next_mux
  import instr_fetch_fsm_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  PCSrc_Enum   pcsrc_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_target_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] xepc_i,
  output logic [31:0] npc_o,
  output logic        misalign_o
);

  logic [31:0] raw;

  // Select the raw target; sequential fetch wraps modulo 2^32
  always_comb begin
    raw = pc_i + 32'd4;
    unique case (pcsrc_i)
      next_pc:        raw = pc_i + 32'd4;
      branch_alu:     raw = alu_target_i;
      branch_pc_jump: raw = jump_target_i;
      xepc:           raw = xepc_i;
      trap_illegal:   raw = TRAP_VEC;
      default:        raw = pc_i + 32'd4;
    endcase
  end

  assign npc_o      = MISALIGN_EN ? raw : {raw[31:2], 2'b00};
  assign misalign_o = MISALIGN_EN & (|raw[1:0]);

endmodule

// File: rtl/instr_fetch_fsm.sv
// IF stage: PC register, next-PC selection and a single-outstanding
// req/gnt/rvalid fetch to instruction memory.
// IFETCH_MISALIGN_EN: misaligned redirect targets skip the fetch and present
// a NOP with fetch_misalign_o set.
module instr_fetch_fsm
  import instr_fetch_fsm_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_pc_i,
  input  PCSrc_Enum   pcsrc_i,
  input  logic [31:0] alu_target_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] xepc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        fetch_done_o,
  output logic        fetch_misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, addr_q, addr_d, pco_q, pco_d, instr_q, instr_d;
  logic         drop_q, drop_d, done_q, done_d, mis_q, mis_d;

  logic [31:0]  npc;
  logic         npc_mis;
  logic         redirect;
  logic         go;
  logic [31:0]  tgt;
  imem_req_t    ireq;
  imem_rsp_t    irsp;

  instr_fetch_fsm_pc_next_mux #(.TRAP_VEC(TRAP_VEC)) u_npc (
    .pcsrc_i       (pcsrc_i),
    .pc_i          (pco_q),
    .alu_target_i  (alu_target_i),
    .jump_target_i (jump_target_i),
    .xepc_i        (xepc_i),
    .npc_o         (npc),
    .misalign_o    (npc_mis)
  );

  assign irsp     = '{gnt: imem_gnt_i, rvalid: imem_rvalid_i, rdata: imem_rdata_i};
  assign ireq     = '{req: (state_q == REQ), addr: addr_q};
  assign redirect = en_pc_i && (pcsrc_i != next_pc);

  // Next-state: handshake progress, redirects and the common "take new target" path
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    pco_d   = pco_q;
    instr_d = instr_q;
    drop_d  = drop_q;
    done_d  = done_q;
    mis_d   = mis_q;
    go      = 1'b0;
    tgt     = npc;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // addr_q holds so the in-flight request completes; its data gets dropped
        if (redirect) begin
          pc_d   = npc;
          drop_d = 1'b1;
        end
        if (irsp.gnt) state_d = WAIT;
      end
      WAIT: begin
        if (irsp.rvalid) begin
          if (redirect) begin
            go  = 1'b1;
            tgt = npc;
          end else if (drop_q) begin
            go  = 1'b1;
            tgt = pc_q;
          end else begin
            state_d = VALID;
            instr_d = irsp.rdata;
            pco_d   = addr_q;
            done_d  = 1'b1;
          end
        end else if (redirect) begin
          pc_d   = npc;
          drop_d = 1'b1;
        end
      end
      VALID: begin
        if (en_pc_i) go = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Misaligned targets are never fetched: present a NOP at that PC instead
    if (go) begin
      pc_d   = tgt;
      drop_d = 1'b0;
      if (MISALIGN_EN && (|tgt[1:0])) begin
        state_d = VALID;
        instr_d = NOP_INSTR;
        pco_d   = tgt;
        done_d  = 1'b1;
        mis_d   = 1'b1;
      end else begin
        state_d = REQ;
        addr_d  = tgt;
        instr_d = NOP_INSTR;
        done_d  = 1'b0;
        mis_d   = 1'b0;
      end
    end
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      pco_q   <= RESET_PC;
      instr_q <= NOP_INSTR;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      pco_q   <= pco_d;
      instr_q <= instr_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req_o       = ireq.req;
  assign imem_addr_o      = ireq.addr;
  assign pc_o             = pco_q;
  assign instr_o          = instr_q;
  assign fetch_done_o     = done_q;
  assign fetch_misalign_o = MISALIGN_EN ? mis_q : 1'b0;

  logic unused_npc_mis;
  assign unused_npc_mis = npc_mis;

endmodule

// File: tb/tb_instr_fetch_fsm.sv
// Directed bench for instr_fetch_fsm. Inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_instr_fetch_fsm;
  import instr_fetch_fsm_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_pc_i;
  PCSrc_Enum   pcsrc_i;
  logic [31:0] alu_target_i, jump_target_i, xepc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o, instr_o;
  logic        fetch_done_o, fetch_misalign_o;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .en_pc_i          (en_pc_i),
    .pcsrc_i          (pcsrc_i),
    .alu_target_i     (alu_target_i),
    .jump_target_i    (jump_target_i),
    .xepc_i           (xepc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .pc_o             (pc_o),
    .instr_o          (instr_o),
    .fetch_done_o     (fetch_done_o),
    .fetch_misalign_o (fetch_misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expects REQ on entry; gnt in that cycle, rvalid the next; ends in VALID
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".req"}, {31'd0, imem_req_o}, 32'd1);
    chk({tag, ".addr"}, imem_addr_o, a);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i    = 1'b0;
    chk({tag, ".wait_done"}, {31'd0, fetch_done_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = d;
    step();
    imem_rvalid_i = 1'b0;
    chk({tag, ".done"}, {31'd0, fetch_done_o}, 32'd1);
    chk({tag, ".pc"}, pc_o, a);
    chk({tag, ".instr"}, instr_o, d);
  endtask

  // One en_pc pulse from VALID
  task automatic advance(input PCSrc_Enum s);
    en_pc_i = 1'b1;
    pcsrc_i = s;
    step();
    en_pc_i = 1'b0;
    pcsrc_i = next_pc;
  endtask

  initial begin
    rst = 1'b1; en_pc_i = 1'b0; pcsrc_i = next_pc;
    alu_target_i = '0; jump_target_i = '0; xepc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    step(); step();
    // 1: reset state, then first fetch at RESET_PC
    chk("rst.req", {31'd0, imem_req_o}, 32'd0);
    chk("rst.instr", instr_o, NOP);
    chk("rst.done", {31'd0, fetch_done_o}, 32'd0);
    chk("rst.pc", pc_o, 32'h0);
    chk("rst.mis", {31'd0, fetch_misalign_o}, 32'd0);
    rst = 1'b0;
    step();  // IDLE -> REQ
    fetch("t1", 32'h0, 32'h0050_0093);

    // 2: sequential advance, gnt held off 5 cycles
    advance(next_pc);
    chk("t2.done_clr", {31'd0, fetch_done_o}, 32'd0);
    chk("t2.instr_nop", instr_o, NOP);
    for (int i = 0; i < 5; i++) begin
      chk("t2.hold_req", {31'd0, imem_req_o}, 32'd1);
      chk("t2.hold_addr", imem_addr_o, 32'h4);
      step();
    end
    fetch("t2", 32'h4, 32'h1111_1111);

    // 3: branch redirect while WAIT, pending data dropped
    advance(next_pc);
    chk("t3.addr8", imem_addr_o, 32'h8);
    imem_gnt_i = 1'b1;
    step();  // -> WAIT
    imem_gnt_i   = 1'b0;
    en_pc_i      = 1'b1;
    pcsrc_i      = branch_alu;
    alu_target_i = 32'h40;
    step();
    en_pc_i       = 1'b0;
    pcsrc_i       = next_pc;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    step();  // stale response dropped -> REQ
    imem_rvalid_i = 1'b0;
    chk("t3.no_done", {31'd0, fetch_done_o}, 32'd0);
    chk("t3.instr_nop", instr_o, NOP);
    fetch("t3", 32'h40, 32'h2222_2222);

    // 4: trap vector, then MRET return
    advance(trap_illegal);
    fetch("t4trap", 32'h100, 32'h3333_3333);
    xepc_i = 32'h88;
    advance(xepc);
    fetch("t4xepc", 32'h88, 32'h4444_4444);

    // 5: wrap at top of address space, reset mid-transaction
    jump_target_i = 32'hFFFF_FFFC;
    advance(branch_pc_jump);
    fetch("t5top", 32'hFFFF_FFFC, 32'h5555_5555);
    advance(next_pc);
    chk("t5.wrap_addr", imem_addr_o, 32'h0);
    imem_gnt_i = 1'b1;
    step();  // -> WAIT
    imem_gnt_i = 1'b0;
    rst = 1'b1;
    step();
    rst           = 1'b0;
    chk("t5.rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("t5.rst_pc", pc_o, 32'h0);
    chk("t5.rst_done", {31'd0, fetch_done_o}, 32'd0);
    chk("t5.rst_instr", instr_o, NOP);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0001;
    step();  // IDLE -> REQ, late rvalid ignored
    chk("t5.late_done", {31'd0, fetch_done_o}, 32'd0);
    chk("t5.late_instr", instr_o, NOP);
    step();  // rvalid in REQ ignored
    imem_rvalid_i = 1'b0;
    chk("t5.req_rv_done", {31'd0, fetch_done_o}, 32'd0);
    fetch("t5re", 32'h0, 32'h6666_6666);

    // 6: misaligned jump target
    jump_target_i = 32'h42;
    advance(branch_pc_jump);
`ifdef IFETCH_MISALIGN_EN
    chk("t6.no_req", {31'd0, imem_req_o}, 32'd0);
    chk("t6.mis", {31'd0, fetch_misalign_o}, 32'd1);
    chk("t6.pc", pc_o, 32'h42);
    chk("t6.instr", instr_o, NOP);
    chk("t6.done", {31'd0, fetch_done_o}, 32'd1);
    alu_target_i = 32'h80;
    advance(branch_alu);
    chk("t6.mis_clr", {31'd0, fetch_misalign_o}, 32'd0);
    fetch("t6", 32'h80, 32'h7777_7777);
`else
    chk("t6.mis_tied", {31'd0, fetch_misalign_o}, 32'd0);
    fetch("t6", 32'h40, 32'h7777_7777);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
